// File: rtl/nonce_dispatch.sv
// nonce_dispatch: front end of the mining hash pipeline.
// Loads a job (nonce range, target, upper m04 word), streams one byte-swapped
// nonce per cycle into the hash core, and collects winning nonces in a small
// first-word-fall-through FIFO. Issue is throttled so that FIFO fill plus
// hashes still in flight never exceeds FIFO_DEPTH, so a winner cannot be lost.
// Optional feature macro: NONCE_DISPATCH_STATS_EN adds the 48-bit hash_cnt
// output (completed hashes since the last job_start, saturating).
module nonce_dispatch #(
  parameter int PIPE_LAT   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int IF_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_start,
  input  logic [31:0] job_lo,
  input  logic [31:0] job_hi,
  input  logic [63:0] job_target,
  input  logic [31:0] job_m04_hi,
  input  logic        abort,
  output logic        vld,
  output logic [63:0] m04,
  output logic [63:0] target,
  output logic        valid,
  input  logic        found,
  input  logic [31:0] nonce_in,
  input  logic        busy,
  output logic        res_valid,
  output logic [31:0] res_nonce,
  input  logic        res_ready,
  output logic        running,
  output logic        done,
  output logic        overflow
`ifdef NONCE_DISPATCH_STATS_EN
  ,
  output logic [47:0] hash_cnt
`endif
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Pipeline latency is informational; the in-flight counter absorbs it.
  logic [31:0] lat_unused;
  assign lat_unused = 32'(PIPE_LAT);

  logic [1:0]       state, state_nx;
  logic [31:0]      hi_q, cur, m04_hi_q;
  logic [IF_W-1:0]  inflight, inflight_nx;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx, fill;
  logic [31:0]      mem [FIFO_DEPTH];
  logic             start, issue, dec, push, pop, full, wr_en, throttle_ok;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  assign res_nonce = mem[rd_ptr[PW-1:0]];

  // Issue decision, FIFO handshakes and next-state / next-count computation.
  always_comb begin
    fill        = wr_ptr - rd_ptr;
    full        = (fill == PTR_W'(FIFO_DEPTH));
    start       = job_start && (state == S_IDLE);
    push        = found && busy;
    pop         = res_valid && res_ready;
    wr_en       = push && (!full || pop);
    throttle_ok = (32'(fill) + 32'(inflight)) < 32'(FIFO_DEPTH);
    issue       = (state == S_RUN) && !abort && throttle_ok;
    dec         = busy && (inflight != {IF_W{1'b0}});

    case ({issue, dec})
      2'b10:   inflight_nx = inflight + IF_W'(1);
      2'b01:   inflight_nx = inflight - IF_W'(1);
      default: inflight_nx = inflight;
    endcase

    if (wr_en) begin
      wr_ptr_nx = wr_ptr + PTR_W'(1);
    end else begin
      wr_ptr_nx = wr_ptr;
    end
    if (pop) begin
      rd_ptr_nx = rd_ptr + PTR_W'(1);
    end else begin
      rd_ptr_nx = rd_ptr;
    end

    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_RUN;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort || (issue && (cur == hi_q))) begin
          state_nx = S_DRAIN;
        end else begin
          state_nx = S_RUN;
        end
      end
      S_DRAIN: begin
        if (inflight_nx == {IF_W{1'b0}}) begin
          state_nx = S_IDLE;
        end else begin
          state_nx = S_DRAIN;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Job registers, FSM state, nonce issue and host-facing status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      hi_q     <= 32'd0;
      cur      <= 32'd0;
      m04_hi_q <= 32'd0;
      inflight <= {IF_W{1'b0}};
      vld      <= 1'b0;
      m04      <= 64'd0;
      target   <= 64'd0;
      valid    <= 1'b0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      inflight <= inflight_nx;
      valid    <= start;
      running  <= (state_nx != S_IDLE);
      done     <= (state == S_DRAIN) && (inflight_nx == {IF_W{1'b0}});
      vld      <= issue;
      if (start) begin
        hi_q     <= job_hi;
        cur      <= job_lo;
        m04_hi_q <= job_m04_hi;
        target   <= job_target;
      end else if (issue) begin
        // cur wraps naturally, so hi < lo walks through 0xFFFFFFFF.
        cur <= cur + 32'd1;
        m04 <= {m04_hi_q, bswap32(cur)};
      end
    end
  end

  // Result FIFO storage, pointers and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= {PTR_W{1'b0}};
      rd_ptr    <= {PTR_W{1'b0}};
      res_valid <= 1'b0;
      overflow  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else begin
      wr_ptr    <= wr_ptr_nx;
      rd_ptr    <= rd_ptr_nx;
      res_valid <= (wr_ptr_nx != rd_ptr_nx);
      if (wr_en) begin
        mem[wr_ptr[PW-1:0]] <= nonce_in;
      end
      if (push && !wr_en) begin
        overflow <= 1'b1;
      end else if (start) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef NONCE_DISPATCH_STATS_EN
  // Completed-hash counter for the current job, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hash_cnt <= 48'd0;
    end else if (start) begin
      hash_cnt <= 48'd0;
    end else if (busy && (hash_cnt != {48{1'b1}})) begin
      hash_cnt <= hash_cnt + 48'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nonce_dispatch.sv
// Scoreboard bench for nonce_dispatch: stimulus pushes expected m04 words and
// expected FIFO pops; a negedge monitor compares whenever vld, valid, done or
// a FIFO pop appears. A behavioural hash core returns busy 4 edges after vld.
module tb_nonce_dispatch;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_start = 1'b0;
  logic [31:0] job_lo = 32'd0, job_hi = 32'd0, job_m04_hi = 32'd0;
  logic [63:0] job_target = 64'd0;
  logic        abort = 1'b0;
  logic        vld, valid, res_valid, running, done, overflow;
  logic [63:0] m04, target;
  logic        found = 1'b0, busy = 1'b0, res_ready = 1'b0;
  logic [31:0] nonce_in = 32'd0, res_nonce;
`ifdef NONCE_DISPATCH_STATS_EN
  logic [47:0] hash_cnt;
`endif

  always #5 clk = ~clk;

  nonce_dispatch #(.PIPE_LAT(4), .FIFO_DEPTH(4), .IF_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .job_start(job_start), .job_lo(job_lo),
    .job_hi(job_hi), .job_target(job_target), .job_m04_hi(job_m04_hi),
    .abort(abort), .vld(vld), .m04(m04), .target(target), .valid(valid),
    .found(found), .nonce_in(nonce_in), .busy(busy), .res_valid(res_valid),
    .res_nonce(res_nonce), .res_ready(res_ready), .running(running),
    .done(done), .overflow(overflow)
`ifdef NONCE_DISPATCH_STATS_EN
    , .hash_cnt(hash_cnt)
`endif
  );

  int n_cmp = 0, n_bad = 0;
  logic [63:0] exp_m04[$];
  logic [31:0] exp_res[$];
  logic [63:0] exp_target = 64'd0;
  int cyc = 0, vld_seen = 0, busy_seen = 0, job_vld = 0;
  int first_vld = 0, last_vld = 0, done_cnt = 0, valid_cnt = 0;
  bit check_gap = 1'b1;
  int found_mode = 0;  // 0 none, 1 nonces 0x11/0x12, 2 every hash
  logic [32:0] line [LAT];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Behavioural hash core + comparator, reset by the same rst_n.
  initial begin
    for (int k = 0; k < LAT; k++) line[k] = 33'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        for (int k = 0; k < LAT; k++) line[k] = 33'd0;
      end else begin
        for (int k = LAT - 1; k > 0; k--) line[k] = line[k-1];
        line[0] = {vld, bswap(m04[31:0])};
      end
      busy     = line[LAT-1][32];
      nonce_in = line[LAT-1][31:0];
      found    = busy && ((found_mode == 2) ||
                 ((found_mode == 1) && ((nonce_in == 32'h11) || (nonce_in == 32'h12))));
    end
  end

  // Monitor: pops scoreboard entries whenever the DUT presents an output.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      vld_seen  = 0;
      busy_seen = 0;
    end else begin
      if (valid) begin
        valid_cnt++;
        job_vld = 0;
        chk("target", target, exp_target);
      end
      if (vld) begin
        if (exp_m04.size() == 0) chk("vld_unexpected", 64'd1, 64'd0);
        else chk("m04", m04, exp_m04.pop_front());
        vld_seen++;
        job_vld++;
        if (job_vld == 1) first_vld = cyc;
        last_vld = cyc;
      end
      if (busy) busy_seen++;
      if (res_valid && res_ready) begin
        if (exp_res.size() == 0) chk("pop_unexpected", 64'd1, 64'd0);
        else chk("res_nonce", {32'd0, res_nonce}, {32'd0, exp_res.pop_front()});
      end
      if (done) begin
        done_cnt++;
        chk("drain_count", 64'(busy_seen), 64'(vld_seen));
        if (check_gap) begin
          chk("done_gap", 64'(cyc - last_vld), 64'd4);
          chk("vld_span", 64'(last_vld - first_vld), 64'(job_vld - 1));
        end
      end
    end
  end

  task automatic start_job(input logic [31:0] lo, input logic [31:0] hi,
                           input logic [63:0] tgt, input logic [31:0] mhi);
    exp_target = tgt;
    job_lo = lo; job_hi = hi; job_target = tgt; job_m04_hi = mhi;
    job_start = 1'b1;
    @(posedge clk); #1;
    job_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int s = done_cnt;
    int i = 0;
    while ((done_cnt == s) && (i < budget)) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk({name, "_done_seen"}, 64'(done_cnt != s), 64'd1);
  endtask

  task automatic pop_one(input logic [31:0] e);
    exp_res.push_back(e);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vld"}, 64'(vld), 64'd0);
    chk({tag, "_m04"}, m04, 64'd0);
    chk({tag, "_target"}, target, 64'd0);
    chk({tag, "_valid"}, 64'(valid), 64'd0);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_res_nonce"}, 64'(res_nonce), 64'd0);
    chk({tag, "_running"}, 64'(running), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk_all_zero("reset");
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain job, no winners.
    found_mode = 0; check_gap = 1'b1;
    exp_m04.push_back({32'hCAFE0001, 32'h10000000});
    exp_m04.push_back({32'hCAFE0001, 32'h11000000});
    exp_m04.push_back({32'hCAFE0001, 32'h12000000});
    exp_m04.push_back({32'hCAFE0001, 32'h13000000});
    start_job(32'h10, 32'h13, 64'h0000_0FFF_FFFF_FFFF, 32'hCAFE0001);
    chk("running_after_start", 64'(running), 64'd1);
    wait_done("plain", 40);
    chk("plain_res_valid", 64'(res_valid), 64'd0);
    chk("plain_running", 64'(running), 64'd0);

    // Range wrapping through 0xFFFFFFFF.
    exp_m04.push_back({32'h12345678, 32'hFEFFFFFF});
    exp_m04.push_back({32'h12345678, 32'hFFFFFFFF});
    exp_m04.push_back({32'h12345678, 32'h00000000});
    exp_m04.push_back({32'h12345678, 32'h01000000});
    start_job(32'hFFFF_FFFE, 32'h0000_0001, 64'h0123_4567_89AB_CDEF, 32'h12345678);
    wait_done("wrap", 40);

    // Winners on 0x11 and 0x12, host not popping.
    found_mode = 1;
    for (int n = 16; n < 20; n++) exp_m04.push_back({32'h0000_00AA, bswap(32'(n))});
    start_job(32'h10, 32'h13, 64'h00FF_0000_0000_0000, 32'h0000_00AA);
    wait_done("found", 40);
    chk("found_res_valid", 64'(res_valid), 64'd1);
    chk("found_head0", 64'(res_nonce), 64'h11);
    chk("found_overflow", 64'(overflow), 64'd0);
    pop_one(32'h11);
    chk("found_head1", 64'(res_nonce), 64'h12);
    pop_one(32'h12);
    chk("found_empty", 64'(res_valid), 64'd0);

    // Every hash wins, host stalled: throttle must hold issue at FIFO_DEPTH.
    found_mode = 2; check_gap = 1'b0;
    for (int n = 256; n < 260; n++) exp_m04.push_back({32'h0BADF00D, bswap(32'(n))});
    start_job(32'h100, 32'h10F, 64'hFFFF_0000_FFFF_0000, 32'h0BADF00D);
    repeat (20) @(posedge clk);
    #1;
    chk("stall_issued", 64'(job_vld), 64'd4);
    chk("stall_res_valid", 64'(res_valid), 64'd1);
    chk("stall_overflow", 64'(overflow), 64'd0);
    exp_m04.push_back({32'h0BADF00D, bswap(32'h104)});
    pop_one(32'h100);
    repeat (20) @(posedge clk);
    #1;
    chk("release_issued", 64'(job_vld), 64'd5);
    chk("release_overflow", 64'(overflow), 64'd0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done("stall_abort", 20);
    for (int n = 257; n < 261; n++) exp_res.push_back(32'(n));
    res_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("stall_drained", 64'(res_valid), 64'd0);
    chk("stall_overflow_end", 64'(overflow), 64'd0);

    // Abort two cycles into a 100-nonce job.
    found_mode = 0; check_gap = 1'b1;
    exp_m04.push_back({32'h5555AAAA, bswap(32'h200)});
    exp_m04.push_back({32'h5555AAAA, bswap(32'h201)});
    start_job(32'h200, 32'h263, 64'h1111_2222_3333_4444, 32'h5555AAAA);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_vld_drop", 64'(vld), 64'd0);
    wait_done("abort", 40);

    // Next job accepted; lo == hi issues exactly one nonce.
    exp_m04.push_back({32'h0000_0042, 32'h05000000});
    start_job(32'h5, 32'h5, 64'h7777_7777_7777_7777, 32'h0000_0042);
    wait_done("single", 40);

    // Reset with hashes in flight and results queued.
    found_mode = 2; check_gap = 1'b0;
    for (int n = 768; n < 772; n++) exp_m04.push_back({32'hD00DFEED, bswap(32'(n))});
    start_job(32'h300, 32'h3FF, 64'h0F0F_0F0F_0F0F_0F0F, 32'hD00DFEED);
    repeat (6) @(posedge clk);
    #3;
    chk("pre_reset_res_valid", 64'(res_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_running", 64'(running), 64'd0);
    chk("post_reset_res_valid", 64'(res_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_vld", 64'(vld), 64'd0);

    chk("m04_queue_empty", 64'(exp_m04.size()), 64'd0);
    chk("res_queue_empty", 64'(exp_res.size()), 64'd0);
    chk("valid_pulses", 64'(valid_cnt), 64'd7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
